// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI frame constants, command codes and master FSM encodings
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_TURN  = 3'd3;
  localparam logic [2:0] ST_RECV  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  // Read-data frames carry a dummy zero payload; the slave ignores it.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0] cmd,
                                                    input logic [DATA_W-1:0] data);
    return {cmd, (cmd == CMD_RD_DATA) ? {DATA_W{1'b0}} : data};
  endfunction

endpackage

// File: rtl/spi_master_shift.sv
// rtl/spi_master_shift.sv - MOSI PISO, MISO SIPO and the bit/phase counter shared by all frame phases
module spi_master_shift
  import spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] frame,
  input  logic               shift_out,
  input  logic               shift_in,
  input  logic               miso,
  input  logic               cnt_load,
  input  logic [3:0]         cnt_init,
  output logic               tx_bit,
  output logic [3:0]         cnt,
  output logic [DATA_W-1:0]  rx_next
);

  logic [FRAME_W-1:0] piso;
  // Only the seven earlier bits are stored; the eighth comes straight from the pin.
  logic [DATA_W-2:0]  rx_hist;

  assign tx_bit  = piso[FRAME_W-1];
  assign rx_next = {rx_hist, miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      piso    <= '0;
      rx_hist <= '0;
      cnt     <= '0;
    end else begin
      if (load) begin
        piso <= frame;
      end else if (shift_out) begin
        piso <= {piso[FRAME_W-2:0], 1'b0};
      end
      if (shift_in) begin
        rx_hist <= rx_next[DATA_W-2:0];
      end
      if (cnt_load) begin
        cnt <= cnt_init;
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - SPI master: command handshake, frame FSM and registered SS_n/MOSI pins
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int TURN_CYC = 2,
  parameter int GAP_CYC  = 1
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [3:0] SHIFT_INIT = 4'(FRAME_W - 1);
  localparam logic [3:0] RECV_INIT  = 4'(DATA_W - 1);
  localparam logic [3:0] TURN_INIT  = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;
  localparam logic [3:0] GAP_INIT   = (GAP_CYC > 1) ? 4'(GAP_CYC - 1) : 4'd0;

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic [1:0]        cmd_q;
  logic              accept;
  logic              cnt_load;
  logic [3:0]        cnt_init;
  logic [3:0]        cnt;
  logic              tx_bit;
  logic [DATA_W-1:0] rx_next;
  logic              frame_next;
  logic              recv_done;

  assign accept    = cmd_valid && cmd_ready;
  assign recv_done = (state == ST_RECV) && (cnt == 4'd0);
  assign frame_next = (next_state == ST_START) || (next_state == ST_SHIFT) ||
                      (next_state == ST_TURN)  || (next_state == ST_RECV);

  spi_master_shift u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .frame     (make_frame(cmd_type, cmd_data)),
    .shift_out (next_state == ST_SHIFT),
    .shift_in  (state == ST_RECV),
    .miso      (MISO),
    .cnt_load  (cnt_load),
    .cnt_init  (cnt_init),
    .tx_bit    (tx_bit),
    .cnt       (cnt),
    .rx_next   (rx_next)
  );

  // Each phase loads the shared counter on entry and leaves when it reaches zero.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_init   = 4'd0;
    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_START;
      end
      ST_START: begin
        next_state = ST_SHIFT;
        cnt_load   = 1'b1;
        cnt_init   = SHIFT_INIT;
      end
      ST_SHIFT: begin
        if (cnt == 4'd0) begin
          cnt_load = 1'b1;
          if (cmd_q != CMD_RD_DATA) begin
            next_state = ST_GAP;
            cnt_init   = GAP_INIT;
          end else if (TURN_CYC > 0) begin
            next_state = ST_TURN;
            cnt_init   = TURN_INIT;
          end else begin
            next_state = ST_RECV;
            cnt_init   = RECV_INIT;
          end
        end
      end
      ST_TURN: begin
        if (cnt == 4'd0) begin
          next_state = ST_RECV;
          cnt_load   = 1'b1;
          cnt_init   = RECV_INIT;
        end
      end
      ST_RECV: begin
        if (cnt == 4'd0) begin
          next_state = ST_GAP;
          cnt_load   = 1'b1;
          cnt_init   = GAP_INIT;
        end
      end
      ST_GAP: begin
        if (cnt == 4'd0) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Pins are driven from next_state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_WR_ADDR;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= next_state;
      cmd_ready <= (next_state == ST_IDLE);
      busy      <= frame_next;
      SS_n      <= !frame_next;
      MOSI      <= (next_state == ST_START) ? cmd_type[1] :
                   (next_state == ST_SHIFT) ? tx_bit : 1'b0;
      rsp_valid <= recv_done;
      if (accept) cmd_q <= cmd_type;
      if (recv_done) rsp_data <= rx_next;
    end
  end

endmodule
